// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch AXI read front end:
// AXI read response codes and the AR channel state encoding.
package ifu_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

endpackage

// File: rtl/ifu_resp_fifo.sv
// Response buffer for fetched instruction words. Head is visible
// combinationally; clr_i empties the buffer on the next edge and wins over
// any push or pop in the same cycle.
module ifu_resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full buffer is legal only when the head leaves this cycle.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // Storage array: written on push, no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy update; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit AXI read front end. Issues one AR per accepted
// fetch request, keeps at most MAX_OUT reads in flight, buffers returned
// words in order and throws away beats belonging to fetches cancelled by a
// flush. Optional performance counters are built only when IFU_PERF_CNT_EN
// is defined; otherwise the perf outputs are tied to zero.
//
// Handshakes: every channel transfers on a cycle where valid && ready are
// both high at the rising clock edge. A valid, once raised, is held with its
// payload stable until that transfer (arvalid/araddr even across a flush).
module ifu_axi_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_ar_stall_cnt,
  output logic [63:0]       perf_discard_cnt
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  ar_state_e         ar_state_q;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              fifo_valid;
  logic              accept, ar_hs, r_hs, drop, push, pop;
  logic [ADDR_W-1:0] aligned_addr;

  assign aligned_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Credit rule: every in-flight read already owns a buffer slot, so R beats
  // can always be taken without back-pressure.
  assign req_ready = rst_n && (ar_state_q == AR_IDLE) && !flush
                   && (int'(outstanding_q) < MAX_OUT)
                   && (int'(outstanding_q) + int'(fifo_count) < FIFO_DEPTH);

  assign rready  = rst_n;
  assign accept  = req_valid && req_ready;
  assign ar_hs   = arvalid_q && arready;
  assign r_hs    = rvalid && rready;
  assign drop    = r_hs && (flush || (discard_q != '0));
  assign push    = r_hs && !drop;
  assign pop     = fifo_valid && rsp_ready;

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rsp_valid = fifo_valid;
  assign rsp_data  = fifo_head[DATA_W:1];
  assign rsp_err   = fifo_head[0];

  // AR channel FSM: capture the aligned address on accept, hold until arready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state_q <= AR_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
    end else begin
      case (ar_state_q)
        AR_IDLE: begin
          if (accept) begin
            ar_state_q <= AR_BUSY;
            arvalid_q  <= 1'b1;
            araddr_q   <= aligned_addr;
          end
        end
        AR_BUSY: begin
          if (ar_hs) begin
            ar_state_q <= AR_IDLE;
            arvalid_q  <= 1'b0;
          end
        end
        default: begin
          ar_state_q <= AR_IDLE;
          arvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Reads in flight: counted from accept until their R beat returns.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !r_hs)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!accept && r_hs) outstanding_d = outstanding_q - OUT_W'(1);
  end

  // Beats still to be dropped: on flush every read in flight is stale; a beat
  // landing in the flush cycle itself is dropped immediately.
  always_comb begin
    discard_d = discard_q;
    if (flush)     discard_d = r_hs ? (outstanding_q - OUT_W'(1)) : outstanding_q;
    else if (drop) discard_d = discard_q - OUT_W'(1);
  end

  // Bookkeeping registers for in-flight and to-be-dropped reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  ifu_resp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (push),
    .wdata_i ({rdata, (rresp != AXI_OKAY)}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_q, perf_stall_q, perf_discard_q;

  // Event counters: buffered words, stalled AR cycles, dropped beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q   <= '0;
      perf_stall_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      if (push)                  perf_fetch_q   <= perf_fetch_q + 64'd1;
      if (arvalid_q && !arready) perf_stall_q   <= perf_stall_q + 64'd1;
      if (drop)                  perf_discard_q <= perf_discard_q + 64'd1;
    end
  end

  assign perf_fetch_cnt    = perf_fetch_q;
  assign perf_ar_stall_cnt = perf_stall_q;
  assign perf_discard_cnt  = perf_discard_q;
`else
  assign perf_fetch_cnt    = '0;
  assign perf_ar_stall_cnt = '0;
  assign perf_discard_cnt  = '0;
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Bench for ifu_axi_fetch: directed scenarios followed by a randomized run,
// with a memory-like AXI slave and an order/epoch reference model.
module tb_ifu_axi_fetch;
  import ifu_pkg::*;

  localparam int MAX_OUT    = 2;
  localparam int FIFO_DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] perf_fetch_cnt, perf_ar_stall_cnt, perf_discard_cnt;

  ifu_axi_fetch #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_ar_stall_cnt(perf_ar_stall_cnt),
    .perf_discard_cnt(perf_discard_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];      // words expected at rsp, in order {data, err}
  logic [32:0] pend_q[$];     // accepted fetches whose beat has not returned
  int          pend_ep_q[$];  // flush epoch of each accepted fetch
  logic [31:0] ar_q[$];       // accepted fetches whose AR is not yet taken
  logic [31:0] slave_q[$];    // addresses the slave still owes a beat for
  int          epoch = 0;
  int          exp_fetch = 0, exp_stall = 0, exp_discard = 0;
  int          n_pops = 0, n_ar = 0;
  logic [31:0] last_pop_data = '0;

  // slave controls
  int ar_pct = 100, r_pct = 100;
  bit ar_hold = 0, r_hold = 0;

  // ---------------- memory contents ----------------
  function automatic logic [31:0] data_fn(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h0000_0013;
    if (a == 32'h0000_0100) return 32'h0000_ABCD;
    return {a[15:0] ^ 16'hBEEF, a[31:16]};
  endfunction

  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    case (a[11:8])
      4'hE:    return AXI_SLVERR;
      4'hD:    return AXI_DECERR;
      default: return AXI_OKAY;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // ---------------- AXI slave ----------------
  initial begin
    bit ar_go, r_go;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    forever begin
      @(posedge clk);
      ar_go = !ar_hold && ($urandom_range(0, 99) < ar_pct);
      r_go  = !r_hold && ($urandom_range(0, 99) < r_pct);
      #1;
      if (!rst_n) begin
        arready = 1'b0;
        rvalid  = 1'b0;
      end else begin
        arready = ar_go;
        rvalid  = r_go && (slave_q.size() != 0);
        if (rvalid) begin
          rdata = data_fn(slave_q[0]);
          rresp = resp_fn(slave_q[0]);
        end
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    int ep;
    bit exp_rdy;
    if (rst_n) begin
      chk("rready", rready, 1);
      chk("rsp_valid", rsp_valid, exp_q.size() != 0);
      exp_rdy = !flush && (ar_q.size() == 0) && (pend_q.size() < MAX_OUT)
                && (pend_q.size() + exp_q.size() < FIFO_DEPTH);
      chk("req_ready", req_ready, exp_rdy);
      chk("arvalid", arvalid, ar_q.size() != 0);
      if (arvalid && ar_q.size() != 0) chk("araddr", araddr, ar_q[0]);
      if (ar_q.size() != 0 && !arready) exp_stall++;

      if (rsp_valid && rsp_ready && !flush) begin
        n_pops++;
        last_pop_data = rsp_data;
        if (exp_q.size() == 0) flag("rsp_unexpected", $sformatf("word %08h with nothing expected", rsp_data));
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[32:1]);
          chk("rsp_err", rsp_err, e[0]);
        end
      end

      if (flush) begin
        exp_q.delete();
        epoch++;
      end

      if (rvalid && rready) begin
        if (slave_q.size() != 0) void'(slave_q.pop_front());
        if (pend_q.size() == 0) flag("r_unexpected", "R beat with no fetch in flight");
        else begin
          e  = pend_q.pop_front();
          ep = pend_ep_q.pop_front();
          if (ep == epoch) begin
            exp_q.push_back(e);
            exp_fetch++;
          end else begin
            exp_discard++;
          end
        end
      end

      if (arvalid && arready) begin
        n_ar++;
        slave_q.push_back(araddr);
        if (ar_q.size() != 0) void'(ar_q.pop_front());
      end

      if (req_valid && req_ready) begin
        logic [31:0] a;
        a = req_addr & ~32'h3;
        ar_q.push_back(a);
        pend_q.push_back({data_fn(a), resp_fn(a) != AXI_OKAY});
        pend_ep_q.push_back(epoch);
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_req(input logic [31:0] a, output int c);
    int n;
    bit ok;
    n = 0; ok = 0; c = -1;
    req_valid = 1'b1;
    req_addr  = a;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        c  = cyc;
      end
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL send_req: addr %08h not accepted, required within 100 cycles", a);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0 || ar_q.size() != 0) && n < 300) begin
      step(1);
      n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_errors++;
      $display("FAIL %s: not drained, pend=%0d buf=%0d ar=%0d, required all 0", name,
               pend_q.size(), exp_q.size(), ar_q.size());
    end
  endtask

  // Waits at negedges for rsp_valid; returns at that negedge.
  task automatic wait_rsp_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
  endtask

  task automatic check_perf(input string name);
`ifdef IFU_PERF_CNT_EN
    chk({name, "_perf_fetch"}, perf_fetch_cnt, 64'(exp_fetch));
    chk({name, "_perf_stall"}, perf_ar_stall_cnt, 64'(exp_stall));
    chk({name, "_perf_discard"}, perf_discard_cnt, 64'(exp_discard));
`else
    chk({name, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
    chk({name, "_perf_stall"}, perf_ar_stall_cnt, 64'd0);
    chk({name, "_perf_discard"}, perf_discard_cnt, 64'd0);
`endif
  endtask

  task automatic clear_model();
    exp_q.delete(); pend_q.delete(); pend_ep_q.delete();
    ar_q.delete(); slave_q.delete();
    exp_fetch = 0; exp_stall = 0; exp_discard = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_arvalid"}, arvalid, 0);
    chk({name, "_rsp_valid"}, rsp_valid, 0);
    chk({name, "_req_ready"}, req_ready, 0);
    chk({name, "_rready"}, rready, 0);
    chk({name, "_araddr"}, araddr, 0);
    check_perf(name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int c, p0, ar0, n;
    bit saw_rdy, acc;

    // Reset state
    req_valid = 1'b1;
    #3;
    check_reset_outputs("reset");
    req_valid = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Single fetch with minimum latency
    rsp_ready = 1'b1;
    send_req(32'h8000_0004, c);
    wait_rsp_valid();
    chk("single_latency", 64'(cyc - c), 3);
    chk("single_data", rsp_data, 32'h0000_0013);
    chk("single_err", rsp_err, 0);
    @(posedge clk); #1;
    wait_idle("single_drain");
    chk("single_pops", n_pops, 1);

    // Error response passes data through
    send_req(32'h0000_0E00, c);
    wait_rsp_valid();
    chk("err_flag", rsp_err, 1);
    chk("err_data", rsp_data, data_fn(32'h0000_0E00));
    @(posedge clk); #1;
    wait_idle("err_drain");
    check_perf("err");

    // Back-pressure: third request waits for buffer credit
    rsp_ready = 1'b0;
    ar0 = n_ar;
    send_req(32'h0000_4000, c);
    send_req(32'h0000_4004, c);
    req_valid = 1'b1;
    req_addr  = 32'h0000_4008;
    saw_rdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready) saw_rdy = 1;
      @(posedge clk); #1;
    end
    chk("bp_ar_count", n_ar - ar0, 2);
    chk("bp_blocked", saw_rdy, 0);
    rsp_ready = 1'b1;
    acc = 0; n = 0;
    while ((n_ar - ar0) < 3 && n < 50) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk); #1;
      if (acc) req_valid = 1'b0;
      n++;
    end
    req_valid = 1'b0;
    chk("bp_third_ar", n_ar - ar0, 3);
    wait_idle("bp_drain");

    // Flush with two fetches in flight, then a fresh fetch
    r_hold = 1;
    send_req(32'h0000_2000, c);
    send_req(32'h0000_2004, c);
    step(3);
    p0 = n_pops;
    pulse_flush();
    r_hold = 0;
    wait_idle("flush_drop");
    send_req(32'h0000_0100, c);
    wait_idle("flush_new");
    chk("flush_pops", n_pops - p0, 1);
    chk("flush_new_data", last_pop_data, 32'h0000_ABCD);
    check_perf("flush");

    // Flush while the AR is stalled
    ar_hold = 1;
    p0 = n_pops;
    send_req(32'h0000_5003, c);
    step(1);
    pulse_flush();
    step(2);
    @(negedge clk);
    chk("stall_araddr", araddr, 32'h0000_5000);
    chk("stall_arvalid", arvalid, 1);
    @(posedge clk); #1;
    ar_hold = 0;
    wait_idle("stall_drain");
    step(2);
    chk("stall_no_rsp", n_pops - p0, 0);
    check_perf("stall");

    // Reset with an AR pending and one buffered word
    rsp_ready = 1'b0;
    send_req(32'h0000_3000, c);
    wait_rsp_valid();
    @(posedge clk); #1;
    ar_hold = 1;
    send_req(32'h0000_3004, c);
    @(negedge clk);
    chk("rst_pre_arvalid", arvalid, 1);
    chk("rst_pre_rsp_valid", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    ar_hold = 0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // Randomized traffic with occasional flushes
    ar_pct = 60;
    r_pct  = 60;
    for (int i = 0; i < 600; i++) begin
      req_valid = $urandom_range(0, 1);
      req_addr  = $urandom();
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step(1);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    ar_pct = 100;
    r_pct  = 100;
    wait_idle("random_drain");
    step(2);
    check_perf("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
